// File: rtl/uart_reception.sv
// uart_reception: 8N1 UART receiver with a two-flop input synchroniser and a
// start-bit centre check. Received bytes go into a hold register that has a
// valid/acknowledge handshake. The receiver also reports overrun (sticky),
// framing error (one-cycle pulse) and busy.
module uart_reception #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int HALF_BIT     = 2604,
    parameter int DATA_BITS    = 8
) (
    input  logic                 Clk_i,
    input  logic                 Reset_i,
    input  logic                 Rx_i,
    input  logic                 Data_Ack_i,
    output logic [DATA_BITS-1:0] Data_o,
    output logic                 Data_Valid_o,
    output logic                 Overrun_o,
    output logic                 Frame_Error_o,
    output logic                 Busy_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK_WAIT
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 rx_meta;
    logic                 rx_s;
    logic                 stop_sample;
    logic                 deliver;

    // Two-flop synchroniser. Both flops reset to the idle (high) line level,
    // so leaving reset cannot produce a false start edge.
    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= Rx_i;
            rx_s    <= rx_meta;
        end
    end

    // Stop-bit centre sample. A high sample there delivers a good byte.
    always_comb begin
        stop_sample = (state == STOP) && (bit_cnt == BIT_LAST);
        deliver     = stop_sample && rx_s;
    end

    // Receive FSM, hold register and status flags, all registered.
    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            bit_idx       <= '0;
            shift_reg     <= '0;
            Data_o        <= '0;
            Data_Valid_o  <= 1'b0;
            Overrun_o     <= 1'b0;
            Frame_Error_o <= 1'b0;
            Busy_o        <= 1'b0;
        end else begin
            Frame_Error_o <= 1'b0;

            // A delivery wins over an acknowledge in the same cycle. The new
            // byte always replaces the old one (newest wins). An overrun is
            // flagged only when the old byte was never acknowledged.
            if (deliver) begin
                Data_o       <= shift_reg;
                Data_Valid_o <= 1'b1;
                if (Data_Valid_o && !Data_Ack_i) begin
                    Overrun_o <= 1'b1;
                end
            end else if (Data_Ack_i && Data_Valid_o) begin
                Data_Valid_o <= 1'b0;
                Overrun_o    <= 1'b0;
            end

            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (!rx_s) begin
                        state  <= START;
                        Busy_o <= 1'b1;
                    end
                end
                START: begin
                    if (bit_cnt == HALF_LAST) begin
                        bit_cnt <= '0;
                        if (rx_s) begin
                            state  <= IDLE;
                            Busy_o <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt   <= '0;
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        bit_idx   <= bit_idx + IDX_W'(1);
                        if (bit_idx == IDX_LAST) begin
                            state <= STOP;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        if (rx_s) begin
                            state  <= IDLE;
                            Busy_o <= 1'b0;
                        end else begin
                            Frame_Error_o <= 1'b1;
                            state         <= BREAK_WAIT;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                BREAK_WAIT: begin
                    bit_cnt <= '0;
                    if (rx_s) begin
                        state  <= IDLE;
                        Busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    Busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_reception.sv
// tb_uart_reception: directed bench for uart_reception at a reduced bit
// period, so that every frame scenario fits in a short run.
module tb_uart_reception;

    localparam int CPB  = 16;
    localparam int HALF = 8;
    localparam int LAT  = 3 + HALF + 9 * CPB;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       ack;
    logic [7:0] data;
    logic       valid;
    logic       ovr;
    logic       fe;
    logic       busy;

    int checks;
    int errors;
    int fe_total;
    int busy_total;

    uart_reception #(
        .CLKS_PER_BIT(CPB),
        .HALF_BIT    (HALF),
        .DATA_BITS   (8)
    ) dut (
        .Clk_i        (clk),
        .Reset_i      (rst),
        .Rx_i         (rx),
        .Data_Ack_i   (ack),
        .Data_o       (data),
        .Data_Valid_o (valid),
        .Overrun_o    (ovr),
        .Frame_Error_o(fe),
        .Busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count frame-error pulse cycles and busy cycles away from the active edge.
    always @(negedge clk) begin
        if (fe === 1'b1) fe_total++;
        if (busy === 1'b1) busy_total++;
    end

    typedef struct {
        logic [7:0] tx;
        logic       stop;
        int         hold;
        logic       do_ack;
        logic [7:0] exp_data;
        logic       exp_valid;
        logic       exp_ovr;
        int         exp_fe;
    } vec_t;

    vec_t vecs[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int extra);
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) tick();
        end
        rx = stop;
        repeat (CPB + extra) tick();
        rx = 1'b1;
    endtask

    initial begin
        int  fe0;
        int  b0;
        int  n;
        logic bad;
        logic seen;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        rx  = 1'b1;
        ack = 1'b0;

        vecs[0] = '{tx: 8'h3C, stop: 1'b1, hold: 0,   do_ack: 1'b0, exp_data: 8'h3C, exp_valid: 1'b1, exp_ovr: 1'b0, exp_fe: 0};
        vecs[1] = '{tx: 8'h81, stop: 1'b1, hold: 0,   do_ack: 1'b1, exp_data: 8'h81, exp_valid: 1'b1, exp_ovr: 1'b1, exp_fe: 0};
        vecs[2] = '{tx: 8'h55, stop: 1'b0, hold: 400, do_ack: 1'b0, exp_data: 8'h81, exp_valid: 1'b0, exp_ovr: 1'b0, exp_fe: 1};
        vecs[3] = '{tx: 8'h12, stop: 1'b1, hold: 0,   do_ack: 1'b1, exp_data: 8'h12, exp_valid: 1'b1, exp_ovr: 1'b0, exp_fe: 0};

        repeat (3) tick();
        rst = 1'b0;
        check("reset_data",  {24'd0, data}, 32'h0);
        check("reset_flags", {28'd0, valid, ovr, fe, busy}, 32'h0);

        // Idle line held high: nothing may happen.
        bad = 1'b0;
        repeat (2000) begin
            tick();
            if (valid || busy || fe || ovr) bad = 1'b1;
        end
        check("idle_quiet", {31'd0, bad}, 32'h0);

        // 0xA5 with latency measurement and an ack one cycle after valid.
        b0 = busy_total;
        seen = 1'b0;
        n = 0;
        fork
            send_frame(8'hA5, 1'b1, 0);
            begin
                @(posedge clk);
                while (!seen && n < 2 * LAT) begin
                    @(posedge clk);
                    #1;
                    n++;
                    if (valid) seen = 1'b1;
                end
                check("a5_valid_seen", {31'd0, seen}, 32'h1);
                check("a5_latency_in_window", {31'd0, (n >= LAT - 1 && n <= LAT + 1)}, 32'h1);
                if (!(n >= LAT - 1 && n <= LAT + 1)) $display("latency measured %0d cycles, window %0d +/- 1", n, LAT);
                check("a5_data", {24'd0, data}, 32'hA5);
                tick();
                ack = 1'b1;
                tick();
                ack = 1'b0;
                check("a5_valid_fall", {31'd0, valid}, 32'h0);
            end
        join
        check("a5_busy_cycles", {31'd0, (busy_total - b0 >= 9 * CPB)}, 32'h1);

        // Table of frames: back-to-back overrun, ack, framing error, recovery.
        for (int i = 0; i < 4; i++) begin
            fe0 = fe_total;
            send_frame(vecs[i].tx, vecs[i].stop, vecs[i].hold);
            if (!vecs[i].stop) repeat (4) tick();
            check($sformatf("vec%0d_data", i),  {24'd0, data},  {24'd0, vecs[i].exp_data});
            check($sformatf("vec%0d_valid", i), {31'd0, valid}, {31'd0, vecs[i].exp_valid});
            check($sformatf("vec%0d_ovr", i),   {31'd0, ovr},   {31'd0, vecs[i].exp_ovr});
            check($sformatf("vec%0d_fe_pulses", i), fe_total - fe0, vecs[i].exp_fe);
            if (vecs[i].do_ack) begin
                ack = 1'b1;
                tick();
                ack = 1'b0;
                check($sformatf("vec%0d_ack_valid", i), {31'd0, valid}, 32'h0);
                check($sformatf("vec%0d_ack_ovr", i),   {31'd0, ovr},   32'h0);
            end
        end

        // Short low glitch on the idle line is rejected at the start sample.
        fe0 = fe_total;
        b0  = busy_total;
        rx  = 1'b0;
        repeat (4) tick();
        rx = 1'b1;
        repeat (3 * CPB) tick();
        check("glitch_busy_seen", {31'd0, (busy_total > b0)}, 32'h1);
        check("glitch_idle", {30'd0, busy, valid}, 32'h0);
        check("glitch_no_fe", fe_total - fe0, 0);

        // Reset during data bit 4 of 0xF0 discards the partial frame.
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 4; i++) begin
            rx = (8'hF0 >> i) & 8'h01;
            repeat (CPB) tick();
        end
        rx = 1'b1;
        repeat (CPB / 2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset_outputs", {20'd0, data, valid, ovr, fe, busy}, 32'h0);
        repeat (6 * CPB) tick();
        check("midreset_stays_idle", {31'd0, busy}, 32'h0);

        fe0 = fe_total;
        send_frame(8'h0F, 1'b1, 0);
        check("post_reset_data",  {24'd0, data},  32'h0F);
        check("post_reset_valid", {31'd0, valid}, 32'h1);
        check("post_reset_ovr",   {31'd0, ovr},   32'h0);
        check("post_reset_fe",    fe_total - fe0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_reception.md
Name: uart_reception

Overview:
- 8N1 UART receiver; the receive-direction counterpart of the board's 9600-baud UART transmitter, on the same 50 MHz clock.
- Deserialises bytes arriving on the FPGA Rx pin from the host PC terminal.
- Presents each byte through a hold register with a valid/acknowledge handshake, so the downstream ADXL345 command/config logic can consume bytes at its own pace.
- Reports framing errors, overruns and activity.

Parameters:
- CLKS_PER_BIT, 5208, clock cycles per UART bit (50 MHz / 9600 baud).
- HALF_BIT, 2604, cycles from start-edge detection to the start-bit centre sample (CLKS_PER_BIT/2).
- DATA_BITS, 8, data bits per frame, LSB first.

Ports:
- Clk_i  input  1  system clock, 50 MHz.
- Reset_i  input  1  synchronous, active-high reset.
- Rx_i  input  1  asynchronous serial line; idle high.
- Data_Ack_i  input  1  one-cycle pulse from consumer; releases the hold register.
- Data_o  output  DATA_BITS  last correctly framed byte.
- Data_Valid_o  output  1  level; high while Data_o holds an unacknowledged byte.
- Overrun_o  output  1  sticky; a byte was overwritten before it was acknowledged.
- Frame_Error_o  output  1  one-cycle pulse on a bad stop bit.
- Busy_o  output  1  high in every state except IDLE.

Behaviour:
- Reset, sampled on the Clk_i rising edge while Reset_i=1:
  - Data_o=0, Data_Valid_o=0, Overrun_o=0, Frame_Error_o=0, Busy_o=0.
  - FSM goes to IDLE; counters and shift register cleared; both synchroniser flops set to 1.
  - Reset asserted mid-frame discards the partial byte; no flags are raised.
- Input synchronisation:
  - Rx_i passes through 2 flops to give rx_s.
  - All decisions use rx_s only, so input-to-decision delay is 2 cycles.
- FSM states: IDLE, START, DATA, STOP, BREAK_WAIT.
- IDLE:
  - rx_s=0 -> START, bit counter cleared.
- START:
  - The counter increments each cycle. At count HALF_BIT-1, rx_s is sampled and the counter is cleared.
  - Sample 0 -> DATA with bit index 0.
  - Sample 1 -> IDLE (glitch rejected; no flag).
- DATA:
  - At count CLKS_PER_BIT-1, rx_s is shifted into the MSB of the shift register (a right shift, giving LSB-first assembly). The counter is cleared and the bit index increments.
  - After the bit with index DATA_BITS-1 -> STOP.
- STOP:
  - At count CLKS_PER_BIT-1, rx_s is sampled.
  - Sample 1 -> deliver the byte (see below), then IDLE.
  - Sample 0 -> Frame_Error_o pulses high for exactly 1 cycle on the next edge; Data_o, Data_Valid_o and Overrun_o are unchanged; go to BREAK_WAIT.
- BREAK_WAIT:
  - Remain until rx_s=1, then IDLE.
  - A held-low line (break) produces exactly one Frame_Error_o pulse and no further frames.
- Delivery (registered, on the edge after the stop sample):
  - Data_o is loaded with the shift register and Data_Valid_o is set to 1.
  - If Data_Valid_o was already 1 and Data_Ack_i=0 on that cycle: Overrun_o is set to 1 and the new byte overwrites Data_o (newest wins).
  - If Data_Ack_i=1 on the delivery cycle: the new byte is loaded, Data_Valid_o stays 1, and no overrun is raised.
- Acknowledge:
  - Data_Ack_i=1 with no delivery in that cycle clears Data_Valid_o and Overrun_o on the next edge.
  - Data_Ack_i while Data_Valid_o=0 is ignored.
- Latency:
  - Data_Valid_o rises 3 + HALF_BIT + 9*CLKS_PER_BIT cycles after the first Clk_i edge at which Rx_i is low, ±1 cycle.
  - At the default parameters this is 49479 ±1 cycles.
- Back-to-back frames: returning to IDLE at the centre of the stop bit allows the next start edge to be accepted with zero idle time.
- Width rules:
  - The bit counter is wide enough for CLKS_PER_BIT-1 and never wraps past it.
  - The bit index is wide enough for DATA_BITS.

Test Plan:
- Reset, then Rx_i held high for 100000 cycles -> Data_Valid_o, Busy_o, Frame_Error_o and Overrun_o stay 0.
- Send 0xA5 as an 8N1 frame at 5208 cycles/bit, with Data_Ack_i 1 cycle after Valid -> Data_o=0xA5; Valid rises at ~49479 cycles and falls 1 cycle after the ack; Busy_o is high during the frame.
- Send 0x3C and 0x81 back-to-back with no ack -> Data_o=0x81, Data_Valid_o=1, Overrun_o=1. A single ack then clears both flags.
- Send 0x55 with the stop bit forced low, holding Rx_i low 20000 extra cycles before release -> exactly one 1-cycle Frame_Error_o pulse; Data_o keeps its previous value; Valid stays 0. The next good frame 0x12 is received correctly.
- 1000-cycle low glitch on the idle line -> FSM returns to IDLE after the start sample; no Valid and no Frame_Error.
- Assert Reset_i for 1 cycle during data bit 4 of 0xF0 -> all outputs 0 the following cycle. The next full frame 0x0F yields Data_o=0x0F with no error flags.
